integral_window_builder: RTL and testbench
==========================================

// Module: integral_window_builder
// PURPOSE
//  Upstream feeder of the second-stage classifier. Accepts a raster pixel stream and builds the integral image on the fly.
//  Keeps INTEGRAL_HEIGHT-1 line buffers of integral rows and a window shift register.
//  Presents every INTEGRAL_WIDTH x INTEGRAL_HEIGHT integral window with a one-cycle o_enable_write pulse.
//  Window pulses are spaced so the classifier can serialise each window into its FIFO.
// PARAMETERS
//  DATA_WIDTH       8    pixel and integral word width; integral sums wrap mod 2^DATA_WIDTH
//  ADDR_WIDTH       10   line-buffer address width; must satisfy 2^ADDR_WIDTH >= FRAME_WIDTH
//  FRAME_WIDTH      640  pixels per row
//  FRAME_HEIGHT     480  rows per frame
//  INTEGRAL_WIDTH   3    window columns
//  INTEGRAL_HEIGHT  3    window rows
//  ENABLE_GAP       10   minimum cycles between o_enable_write rising edges; default is INTEGRAL_WIDTH*INTEGRAL_HEIGHT+1
// PORTS
//  clk_fpga          in   1   single clock; all logic on posedge
//  reset_fpga        in   1   synchronous reset, active-low
//  i_pixel           in   DATA_WIDTH   pixel value, raster order, row 0 first
//  i_pixel_valid     in   1   pixel offered this cycle
//  o_pixel_ready     out  1   block accepts i_pixel this cycle; a pixel transfers when valid&&ready
//  o_integral_image  out  DATA_WIDTH x (INTEGRAL_WIDTH*INTEGRAL_HEIGHT)   window, unpacked array
//  o_enable_write    out  1   one-cycle pulse: o_integral_image holds a new valid window
//  o_frame_done      out  1   one-cycle pulse after the last pixel of a frame has been processed
// BEHAVIOUR
//  Reset (reset_fpga==0 at posedge) has priority over everything:
//  - clears x/y counters, line buffers' valid tags, window regs, o_integral_image, gap counter
//  - outputs after reset: o_enable_write=0, o_frame_done=0, o_pixel_ready=1
//  - reset mid-frame discards the partial frame; the next accepted pixel is (0,0)
//  Integral recursion for pixel (x,y):
//  - rowsum(x,y) = rowsum(x-1,y) + p, with rowsum(-1,y)=0
//  - ii(x,y) = rowsum(x,y) + ii(x,y-1), with ii(x,-1)=0
//  - all adds are DATA_WIDTH wide; carries are discarded
//  Line buffers: INTEGRAL_HEIGHT-1 buffers of FRAME_WIDTH words, each read and written at address x.
//  Window: INTEGRAL_HEIGHT shift rows of INTEGRAL_WIDTH words, shifted left on each accepted pixel.
//  - index = r*INTEGRAL_WIDTH + c
//  - r=0 is the top (oldest) row; c=0 is the leftmost column
//  - index (H*W-1) = ii(x,y), the bottom-right entry
//  Window is valid when x>=INTEGRAL_WIDTH-1 and y>=INTEGRAL_HEIGHT-1; earlier positions never pulse.
//  Latency: pixel accepted at cycle t -> o_enable_write=1 at cycle t+2 with that window.
//  - o_integral_image is held stable until the next pulse
//  FSM:
//  - S_FILL: y < INTEGRAL_HEIGHT-1; ready=1, no pulses.
//  - S_RUN: pulses allowed; on a valid window -> S_HOLD.
//  - S_HOLD: o_pixel_ready=0 until ENABLE_GAP cycles since the last pulse have elapsed, then -> S_RUN.
//  - S_DONE: entered after pixel (FRAME_WIDTH-1, FRAME_HEIGHT-1) completes its pipeline.
//  - S_DONE behaviour: o_frame_done=1 for one cycle, counters cleared, -> S_FILL.
//  - Only windows ready would violate the gap; pixels in non-window positions are accepted at full rate in S_RUN.
//  Row wrap: x==FRAME_WIDTH-1 -> x=0, y++, rowsum cleared; windows never mix columns from two rows.
//  Stall: i_pixel_valid=0 freezes counters and pipeline input; in-flight window still pulses at t+2.
//  o_frame_done and o_enable_write may be high in the same cycle (last window of the frame).
// TESTING
//  T1 All-ones 4x4 frame (W=H=3, DATA_WIDTH=8), pixel (2,2):
//     -> first pulse, window {1,2,3,2,4,6,3,6,9}
//  T2 Same frame, pixel (3,2):
//     -> window {2,3,4,4,6,8,6,9,12}
//     -> exactly 4 pulses per frame, each >=10 cycles apart; one o_frame_done after the last
//  T3 All-255 4x4 frame:
//     -> ii(0,0)=255, ii(1,0)=254, ii(1,1)=252 (wrap)
//     -> window at (2,2) = {255,254,253,254,252,250,253,250,247}
//  T4 Continuous i_pixel_valid=1:
//     -> o_pixel_ready drops after each window pixel and returns exactly ENABLE_GAP cycles after the pulse
//     -> no pixel lost or duplicated (verify against a reference model)
//  T5 reset_fpga=0 for 1 cycle mid-row 2, then a fresh all-ones frame:
//     -> output identical to T1/T2; no stale pulse after reset
//  T6 Random i_pixel_valid gaps on a random 8x6 frame:
//     -> every window matches the model; latency from acceptance to pulse is 2 cycles

Source files
------------

// File: rtl/integral_window_builder_if.sv
// Pixel-in / window-out bundle for the integral window builder.
interface integral_window_builder_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int WINDOW_SIZE = 9
);
  logic [DATA_WIDTH-1:0] i_pixel;
  logic                  i_pixel_valid;
  logic                  o_pixel_ready;
  logic [DATA_WIDTH-1:0] o_integral_image [WINDOW_SIZE];
  logic                  o_enable_write;
  logic                  o_frame_done;

  modport master (
    output i_pixel, i_pixel_valid,
    input  o_pixel_ready, o_integral_image, o_enable_write, o_frame_done
  );

  modport slave (
    input  i_pixel, i_pixel_valid,
    output o_pixel_ready, o_integral_image, o_enable_write, o_frame_done
  );
endinterface

// File: rtl/integral_window_builder.sv
// Builds the integral image of a raster pixel stream and emits every
// INTEGRAL_WIDTH x INTEGRAL_HEIGHT integral window, spaced by ENABLE_GAP cycles.
module integral_window_builder #(
  parameter int DATA_WIDTH      = 8,
  parameter int ADDR_WIDTH      = 10,
  parameter int FRAME_WIDTH     = 640,
  parameter int FRAME_HEIGHT    = 480,
  parameter int INTEGRAL_WIDTH  = 3,
  parameter int INTEGRAL_HEIGHT = 3,
  parameter int ENABLE_GAP      = INTEGRAL_WIDTH * INTEGRAL_HEIGHT + 1
) (
  input logic                      clk_fpga,
  input logic                      reset_fpga,
  integral_window_builder_if.slave bus
);
  localparam int W  = INTEGRAL_WIDTH;
  localparam int H  = INTEGRAL_HEIGHT;
  localparam int YW = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;
  localparam int GW = $clog2(ENABLE_GAP + 2);

  typedef enum logic [1:0] {S_FILL, S_RUN, S_HOLD, S_DONE} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] x;
  logic [YW-1:0]         y;
  logic [DATA_WIDTH-1:0] rowsum, rowsum_nxt, above, ii_nxt;
  logic [DATA_WIDTH-1:0] lb  [H-1][FRAME_WIDTH];
  logic [DATA_WIDTH-1:0] win [H][W];
  logic [DATA_WIDTH-1:0] col [H];
  logic [GW-1:0]         gap_left;
  logic                  row_end, last_pos, win_pos;
  logic                  ready, accept, done_now, p1_valid;

  always_comb begin
    row_end    = (x == ADDR_WIDTH'(FRAME_WIDTH - 1));
    last_pos   = row_end && (y == YW'(FRAME_HEIGHT - 1));
    win_pos    = (x >= ADDR_WIDTH'(W - 1)) && (y >= YW'(H - 1));
    rowsum_nxt = rowsum + bus.i_pixel;
    // Row 0 has no line above; masking by y avoids clearing the buffers on reset.
    above      = (y == '0) ? '0 : lb[0][x];
    ii_nxt     = rowsum_nxt + above;
    for (int unsigned r = 0; r < H - 1; r++) col[r] = lb[H-2-r][x];
    col[H-1]   = ii_nxt;
  end

  // Gap only throttles window pixels; non-window pixels flow at full rate.
  always_comb begin
    ready    = 1'b1;
    done_now = 1'b0;
    case (state)
      S_RUN:   ready = !(win_pos && (gap_left != '0));
      S_HOLD:  ready = 1'b0;
      S_DONE:  begin
        ready    = 1'b0;
        done_now = 1'b1;
      end
      default: ready = 1'b1;
    endcase
  end

  assign accept            = bus.i_pixel_valid && ready;
  assign bus.o_pixel_ready = ready;

  always_comb begin
    state_nxt = state;
    case (state)
      S_FILL: if (accept && row_end && (y == YW'(H - 2))) state_nxt = S_RUN;
      S_RUN: begin
        if (accept && last_pos)     state_nxt = S_DONE;
        else if (accept && win_pos) state_nxt = S_HOLD;
      end
      S_HOLD:  if (gap_left <= GW'(1)) state_nxt = S_RUN;
      S_DONE:  state_nxt = S_FILL;
      default: state_nxt = S_FILL;
    endcase
  end

  always_ff @(posedge clk_fpga) begin
    if (!reset_fpga) begin
      state              <= S_FILL;
      x                  <= '0;
      y                  <= '0;
      rowsum             <= '0;
      gap_left           <= '0;
      p1_valid           <= 1'b0;
      bus.o_enable_write <= 1'b0;
      bus.o_frame_done   <= 1'b0;
      for (int unsigned r = 0; r < H; r++)
        for (int unsigned c = 0; c < W; c++) win[r][c] <= '0;
      for (int unsigned i = 0; i < W * H; i++) bus.o_integral_image[i] <= '0;
    end else begin
      state              <= state_nxt;
      p1_valid           <= accept && win_pos;
      bus.o_enable_write <= p1_valid;
      bus.o_frame_done   <= done_now;
      if (accept && win_pos)   gap_left <= GW'(ENABLE_GAP + 1);
      else if (gap_left != '0) gap_left <= gap_left - 1'b1;
      if (accept) begin
        rowsum <= row_end ? '0 : rowsum_nxt;
        x      <= row_end ? '0 : x + 1'b1;
        if (row_end) y <= last_pos ? '0 : y + 1'b1;
        for (int unsigned r = 0; r < H; r++) begin
          for (int unsigned c = 0; c < W - 1; c++) win[r][c] <= win[r][c+1];
          win[r][W-1] <= col[r];
        end
      end
      if (p1_valid)
        for (int unsigned r = 0; r < H; r++)
          for (int unsigned c = 0; c < W; c++) bus.o_integral_image[r*W+c] <= win[r][c];
    end
  end

  always_ff @(posedge clk_fpga) begin
    if (reset_fpga && accept) begin
      lb[0][x] <= ii_nxt;
      for (int unsigned k = 1; k < H - 1; k++) lb[k][x] <= lb[k-1][x];
    end
  end
endmodule

// File: tb/tb_integral_window_builder.sv
// Directed bench: 4x4 frames on one instance, a random 8x6 frame on another.
module tb_integral_window_builder;
  localparam int DW  = 8;
  localparam int N   = 9;
  localparam int GAP = 10;

  typedef struct packed {
    int              cyc;
    logic [N*DW-1:0] win;
  } pulse_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  pulse_t        pq_a[$], pq_b[$];
  int            dq_a[$], dq_b[$];
  logic [DW-1:0] fa[48], fb[48];
  int            acc_a[48], acc_b[48];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  integral_window_builder_if #(.DATA_WIDTH(DW), .WINDOW_SIZE(N)) bus_a ();
  integral_window_builder_if #(.DATA_WIDTH(DW), .WINDOW_SIZE(N)) bus_b ();

  integral_window_builder #(
    .DATA_WIDTH(8), .ADDR_WIDTH(2), .FRAME_WIDTH(4), .FRAME_HEIGHT(4),
    .INTEGRAL_WIDTH(3), .INTEGRAL_HEIGHT(3), .ENABLE_GAP(GAP)
  ) dut_a (.clk_fpga(clk), .reset_fpga(rst_n), .bus(bus_a));

  integral_window_builder #(
    .DATA_WIDTH(8), .ADDR_WIDTH(3), .FRAME_WIDTH(8), .FRAME_HEIGHT(6),
    .INTEGRAL_WIDTH(3), .INTEGRAL_HEIGHT(3), .ENABLE_GAP(GAP)
  ) dut_b (.clk_fpga(clk), .reset_fpga(rst_n), .bus(bus_b));

  always @(negedge clk) begin : mon
    logic [N*DW-1:0] wa, wb;
    for (int i = 0; i < N; i++) begin
      wa[i*DW +: DW] = bus_a.o_integral_image[i];
      wb[i*DW +: DW] = bus_b.o_integral_image[i];
    end
    if (bus_a.o_enable_write === 1'b1) pq_a.push_back('{cyc, wa});
    if (bus_b.o_enable_write === 1'b1) pq_b.push_back('{cyc, wb});
    if (bus_a.o_frame_done === 1'b1) dq_a.push_back(cyc);
    if (bus_b.o_frame_done === 1'b1) dq_b.push_back(cyc);
  end

  task automatic chk(input string tag, input logic [N*DW-1:0] obs, input logic [N*DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N*DW-1:0] pk(input int v0, v1, v2, v3, v4, v5, v6, v7, v8);
    return {v8[7:0], v7[7:0], v6[7:0], v5[7:0], v4[7:0], v3[7:0], v2[7:0], v1[7:0], v0[7:0]};
  endfunction

  // Direct rectangle sum, independent of the row/column recursion.
  function automatic logic [DW-1:0] ii_ref(input logic [DW-1:0] f[48], input int fw, input int x, input int y);
    logic [DW-1:0] s = '0;
    for (int j = 0; j <= y; j++)
      for (int i = 0; i <= x; i++) s = s + f[j*fw+i];
    return s;
  endfunction

  function automatic logic [N*DW-1:0] win_ref(input logic [DW-1:0] f[48], input int fw, input int x, input int y);
    logic [N*DW-1:0] w;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) w[(r*3+c)*DW +: DW] = ii_ref(f, fw, x-2+c, y-2+r);
    return w;
  endfunction

  task automatic send_a(input logic [DW-1:0] p, input int idx);
    int n = 0;
    bus_a.i_pixel       = p;
    bus_a.i_pixel_valid = 1'b1;
    while (bus_a.o_pixel_ready !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
    if (n >= 100) begin total++; bad++; $error("FAIL ready_timeout_a observed=0 expected=1"); end
    acc_a[idx] = cyc;
    @(posedge clk); #1;
  endtask

  task automatic send_b(input logic [DW-1:0] p, input int idx);
    int n = 0;
    bus_b.i_pixel       = p;
    bus_b.i_pixel_valid = 1'b1;
    while (bus_b.o_pixel_ready !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
    if (n >= 100) begin total++; bad++; $error("FAIL ready_timeout_b observed=0 expected=1"); end
    acc_b[idx] = cyc;
    @(posedge clk); #1;
  endtask

  task automatic frame_a();
    pq_a.delete();
    dq_a.delete();
    for (int i = 0; i < 16; i++) send_a(fa[i], i);
    bus_a.i_pixel_valid = 1'b0;
    repeat (20) begin @(posedge clk); #1; end
  endtask

  task automatic check_a(input string tag);
    int pos[4] = '{10, 11, 14, 15};
    chk({tag, "_count"}, pq_a.size(), 4);
    chk({tag, "_done_count"}, dq_a.size(), 1);
    for (int k = 0; k < 4 && k < pq_a.size(); k++) begin
      chk({tag, "_win"}, pq_a[k].win, win_ref(fa, 4, pos[k] % 4, pos[k] / 4));
      chk({tag, "_latency"}, pq_a[k].cyc, acc_a[pos[k]] + 2);
    end
    if (pq_a.size() == 4 && dq_a.size() == 1) begin
      chk({tag, "_done_cycle"}, dq_a[0], pq_a[3].cyc);
      chk({tag, "_spacing"}, (pq_a[1].cyc - pq_a[0].cyc >= GAP) && (pq_a[2].cyc - pq_a[1].cyc >= GAP)
          && (pq_a[3].cyc - pq_a[2].cyc >= GAP), 1);
    end
  endtask

  initial begin
    int k;
    bus_a.i_pixel = '0; bus_a.i_pixel_valid = 1'b0;
    bus_b.i_pixel = '0; bus_b.i_pixel_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("reset_ready_a", bus_a.o_pixel_ready, 1);
    chk("reset_enable_a", bus_a.o_enable_write, 0);
    chk("reset_done_a", bus_a.o_frame_done, 0);
    chk("reset_image_a", bus_a.o_integral_image[8], 0);
    chk("reset_ready_b", bus_b.o_pixel_ready, 1);
    rst_n = 1'b1;

    // all-ones frame
    for (int i = 0; i < 48; i++) fa[i] = 8'd1;
    frame_a();
    check_a("t1t2");
    if (pq_a.size() == 4) begin
      chk("t1_win22", pq_a[0].win, pk(1, 2, 3, 2, 4, 6, 3, 6, 9));
      chk("t2_win32", pq_a[1].win, pk(2, 3, 4, 4, 6, 8, 6, 9, 12));
      chk("t2_win33", pq_a[3].win, pk(4, 6, 8, 6, 9, 12, 8, 12, 16));
    end

    // all-255 frame: sums wrap
    for (int i = 0; i < 48; i++) fa[i] = 8'd255;
    frame_a();
    check_a("t3");
    if (pq_a.size() == 4) begin
      chk("t3_win22", pq_a[0].win, pk(255, 254, 253, 254, 252, 250, 253, 250, 247));
      chk("t3_win33", pq_a[3].win, pk(252, 250, 248, 250, 247, 244, 248, 244, 240));
    end

    // continuous valid, ramp pixels: exact ready return after each pulse
    for (int i = 0; i < 48; i++) fa[i] = 8'((i * 17 + 3) % 256);
    frame_a();
    check_a("t4");
    if (pq_a.size() == 4) begin
      chk("t4_ready_return_1", acc_a[11], pq_a[0].cyc + GAP);
      chk("t4_ready_return_3", acc_a[15], pq_a[2].cyc + GAP);
      chk("t4_fullrate_row3", acc_a[13], acc_a[12] + 1);
    end

    // reset mid-row 2 with a window in flight, then a fresh all-ones frame
    for (int i = 0; i < 48; i++) fa[i] = 8'd1;
    pq_a.delete();
    for (int i = 0; i < 11; i++) send_a(fa[i], i);
    bus_a.i_pixel_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("t5_ready_after_reset", bus_a.o_pixel_ready, 1);
    chk("t5_enable_after_reset", bus_a.o_enable_write, 0);
    repeat (5) begin @(posedge clk); #1; end
    chk("t5_no_stale_pulse", pq_a.size(), 0);
    frame_a();
    check_a("t5");
    if (pq_a.size() == 4) chk("t5_win22", pq_a[0].win, pk(1, 2, 3, 2, 4, 6, 3, 6, 9));

    // random 8x6 frame with random valid gaps
    for (int i = 0; i < 48; i++) fb[i] = 8'($urandom_range(0, 255));
    pq_b.delete();
    dq_b.delete();
    for (int i = 0; i < 48; i++) begin
      bus_b.i_pixel_valid = 1'b0;
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      send_b(fb[i], i);
    end
    bus_b.i_pixel_valid = 1'b0;
    repeat (30) begin @(posedge clk); #1; end
    chk("t6_count", pq_b.size(), 24);
    chk("t6_done_count", dq_b.size(), 1);
    k = 0;
    for (int y = 2; y < 6; y++)
      for (int x = 2; x < 8; x++) begin
        if (k < pq_b.size()) begin
          chk("t6_win", pq_b[k].win, win_ref(fb, 8, x, y));
          chk("t6_latency", pq_b[k].cyc, acc_b[y*8+x] + 2);
        end
        k++;
      end
    if (pq_b.size() == 24 && dq_b.size() == 1) chk("t6_done_cycle", dq_b[0], pq_b[23].cyc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
